// File: rtl/pal_video_timing.sv
// rtl/pal_video_timing.sv - progressive PAL 720x576p50 timing generator gated by PLL lock
// Optional frame counter output enabled by PAL_TIMING_FRAME_COUNT_EN.
module pal_video_timing #(
  parameter int H_ACTIVE      = 720,
  parameter int H_FP          = 12,
  parameter int H_SYNC        = 64,
  parameter int H_BP          = 68,
  parameter int V_ACTIVE      = 576,
  parameter int V_FP          = 5,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 39,
  parameter bit SYNC_NEG      = 1'b1,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
`ifdef PAL_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || SETTLE_CYCLES < 1) begin : g_bad_params
      $error("pal_video_timing: totals must be <= 1024 and SETTLE_CYCLES >= 1");
    end
  endgenerate

  // 11-bit decode constants so a sync end of exactly 1024 does not wrap
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic SYNC_IDLE = SYNC_NEG;
  localparam logic SYNC_ACT  = ~SYNC_NEG;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t        state;
  logic          lk_meta, lk;
  logic [SW-1:0] scnt;
  logic [9:0]    h, v;
  logic [10:0]   h11, v11;

  assign h11 = {1'b0, h};
  assign v11 = {1'b0, v};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lk_meta     <= 1'b0;
      lk          <= 1'b0;
      state       <= WAIT_LOCK;
      scnt        <= '0;
      h           <= '0;
      v           <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
`ifdef PAL_TIMING_FRAME_COUNT_EN
      frame_count <= '0;
`endif
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;

      // Idle outputs unless the RUN branch below overrides them
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
`ifdef PAL_TIMING_FRAME_COUNT_EN
      frame_count <= '0;
`endif

      if (!lk) begin
        state <= WAIT_LOCK;
        scnt  <= '0;
        h     <= '0;
        v     <= '0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state <= SETTLE;
            scnt  <= '0;
          end
          SETTLE: begin
            if (scnt == S_LAST) begin
              state <= RUN;
              h     <= '0;
              v     <= '0;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          RUN: begin
            x           <= h;
            y           <= v;
            de          <= (h11 < H_ACT) && (v11 < V_ACT);
            hsync       <= (h11 >= HS_BEG && h11 < HS_END) ? SYNC_ACT : SYNC_IDLE;
            vsync       <= (v11 >= VS_BEG && v11 < VS_END) ? SYNC_ACT : SYNC_IDLE;
            line_start  <= (h == 10'd0);
            frame_start <= (h == 10'd0) && (v == 10'd0);
            running     <= 1'b1;
`ifdef PAL_TIMING_FRAME_COUNT_EN
            frame_count <= (h == 10'd0 && v == 10'd0) ? frame_count + 8'd1 : frame_count;
`endif
            if (h == H_LAST) begin
              h <= '0;
              v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
              h <= h + 10'd1;
            end
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pal_video_timing.sv
// tb/tb_pal_video_timing.sv - directed vector bench for pal_video_timing on a shrunk 16x10 raster
module tb_pal_video_timing;

  localparam int S = 8;
  localparam int RUN_LAT = S + 4;
  localparam int NV = 19;

  logic       clk, resetn, pll_locked;
  logic       hsync, vsync, de, line_start, frame_start, running;
  logic [9:0] x, y;
`ifdef PAL_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  int total = 0;
  int bad   = 0;

  pal_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_NEG(1'b1), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
`ifdef PAL_TIMING_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] ex, ey;
    logic       ede, ehs, evs, els, efs;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(x), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_hs"}, 32'(hsync), 32'd1);
    chk({tag, "_vs"}, 32'(vsync), 32'd1);
    chk({tag, "_ls"}, 32'(line_start), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_run"}, 32'(running), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (running !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  int n, de_cnt, ls_cnt, fs_cnt, hs_cnt, vs_cnt, idle_bad;

  initial begin
    vecs[0]  = '{0,   10'd0,  10'd0, 1, 1, 1, 1, 1};
    vecs[1]  = '{7,   10'd7,  10'd0, 1, 1, 1, 0, 0};
    vecs[2]  = '{8,   10'd8,  10'd0, 0, 1, 1, 0, 0};
    vecs[3]  = '{9,   10'd9,  10'd0, 0, 1, 1, 0, 0};
    vecs[4]  = '{10,  10'd10, 10'd0, 0, 0, 1, 0, 0};
    vecs[5]  = '{12,  10'd12, 10'd0, 0, 0, 1, 0, 0};
    vecs[6]  = '{13,  10'd13, 10'd0, 0, 1, 1, 0, 0};
    vecs[7]  = '{15,  10'd15, 10'd0, 0, 1, 1, 0, 0};
    vecs[8]  = '{16,  10'd0,  10'd1, 1, 1, 1, 1, 0};
    vecs[9]  = '{95,  10'd15, 10'd5, 0, 1, 1, 0, 0};
    vecs[10] = '{96,  10'd0,  10'd6, 0, 1, 1, 1, 0};
    vecs[11] = '{111, 10'd15, 10'd6, 0, 1, 1, 0, 0};
    vecs[12] = '{112, 10'd0,  10'd7, 0, 1, 0, 1, 0};
    vecs[13] = '{122, 10'd10, 10'd7, 0, 0, 0, 0, 0};
    vecs[14] = '{143, 10'd15, 10'd8, 0, 1, 0, 0, 0};
    vecs[15] = '{144, 10'd0,  10'd9, 0, 1, 1, 1, 0};
    vecs[16] = '{159, 10'd15, 10'd9, 0, 1, 1, 0, 0};
    vecs[17] = '{160, 10'd0,  10'd0, 1, 1, 1, 1, 1};
    vecs[18] = '{176, 10'd0,  10'd1, 1, 1, 1, 1, 0};

    resetn = 1'b0;
    pll_locked = 1'b1;
    repeat (5) step();
    chk_idle("reset");

    @(negedge clk);
    resetn = 1'b1;
    wait_run(n);
    chk("startup_latency", 32'(n), 32'(RUN_LAT));

    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) step();
      for (int k = 0; k < NV; k++) begin
        if (vecs[k].cyc == t) begin
          chk($sformatf("t%0d_x", t), 32'(x), 32'(vecs[k].ex));
          chk($sformatf("t%0d_y", t), 32'(y), 32'(vecs[k].ey));
          chk($sformatf("t%0d_de", t), 32'(de), 32'(vecs[k].ede));
          chk($sformatf("t%0d_hs", t), 32'(hsync), 32'(vecs[k].ehs));
          chk($sformatf("t%0d_vs", t), 32'(vsync), 32'(vecs[k].evs));
          chk($sformatf("t%0d_ls", t), 32'(line_start), 32'(vecs[k].els));
          chk($sformatf("t%0d_fs", t), 32'(frame_start), 32'(vecs[k].efs));
        end
      end
      if (t < 160) begin
        de_cnt += int'(de);
        ls_cnt += int'(line_start);
        fs_cnt += int'(frame_start);
        hs_cnt += int'(!hsync);
        vs_cnt += int'(!vsync);
      end
    end
    chk("frame_de_count", 32'(de_cnt), 32'd48);
    chk("frame_ls_count", 32'(ls_cnt), 32'd10);
    chk("frame_fs_count", 32'(fs_cnt), 32'd1);
    chk("frame_hs_count", 32'(hs_cnt), 32'd30);
    chk("frame_vs_count", 32'(vs_cnt), 32'd32);

    // Lock loss mid-frame at line 3
    repeat (9) step();
    chk("pre_drop_y", 32'(y), 32'd3);
    chk("pre_drop_x", 32'(x), 32'd0);
    @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) step();
    chk_idle("drop");
    idle_bad = 0;
    repeat (7) begin
      step();
      if (running !== 1'b0 || de !== 1'b0 || hsync !== 1'b1) idle_bad++;
    end
    chk("drop_hold_idle", 32'(idle_bad), 32'd0);
    @(negedge clk);
    pll_locked = 1'b1;
    wait_run(n);
    chk("relock_latency", 32'(n), 32'(RUN_LAT));
    chk("relock_x", 32'(x), 32'd0);
    chk("relock_y", 32'(y), 32'd0);
    chk("relock_fs", 32'(frame_start), 32'd1);
    chk("relock_de", 32'(de), 32'd1);

`ifdef PAL_TIMING_FRAME_COUNT_EN
    chk("fc_first", 32'(frame_count), 32'd1);
    fs_cnt = 0;
    n = 0;
    while (fs_cnt < 256 && n < 257 * 160 + 50) begin
      step();
      n++;
      fs_cnt += int'(frame_start);
    end
    chk("fc_frames_seen", 32'(fs_cnt), 32'd256);
    chk("fc_wrap", 32'(frame_count), 32'd1);
    @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) step();
    chk("fc_cleared", 32'(frame_count), 32'd0);
    @(negedge clk);
    pll_locked = 1'b1;
    wait_run(n);
`endif

    // One-cycle lock glitch during SETTLE must restart the full settle period
    @(negedge clk);
    pll_locked = 1'b0;
    repeat (6) step();
    @(negedge clk);
    pll_locked = 1'b1;
    repeat (6) step();
    chk("glitch_pre_run", 32'(running), 32'd0);
    @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_run(n);
    chk("glitch_latency", 32'(n), 32'(RUN_LAT));
    chk("glitch_x", 32'(x), 32'd0);
    chk("glitch_y", 32'(y), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
